// File: rtl/memory_share_rr.sv
// rtl/memory_share_rr.sv - round-robin shared single-port RAM for NUM_PORTS requesters (option: HOST_PRIORITY_EN)
module memory_share_rr #(
    parameter int NUM_PORTS  = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_LSB   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
    output logic [NUM_PORTS-1:0]            gnt,
    output logic [NUM_PORTS-1:0]            rvalid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
    output logic [NUM_PORTS-1:0]            err
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int IW = ADDR_WIDTH - ADDR_LSB;
    localparam int AW = $clog2(DEPTH);
`ifdef HOST_PRIORITY_EN
    // Port 0 sits outside the rotation, so the pointer starts at the first rotating port.
    localparam logic [PW-1:0] RR_RESET = PW'(1);
`else
    localparam logic [PW-1:0] RR_RESET = '0;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         gnt_idx;
    logic [PW-1:0]         rr_next;
    logic                  any_req;
    logic                  grant;
    logic                  g_we;
    logic [IW-1:0]         g_word;
    logic [DATA_WIDTH-1:0] g_din;
    logic                  in_range;

    // Round-robin search starting at rr_ptr; lowest offset from the pointer wins.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
`ifdef HOST_PRIORITY_EN
        for (int i = NUM_PORTS - 2; i >= 0; i--) begin
            if (req[1 + ((int'(rr_ptr) - 1 + i) % (NUM_PORTS - 1))]) begin
                gnt_idx = PW'(1 + ((int'(rr_ptr) - 1 + i) % (NUM_PORTS - 1)));
                any_req = 1'b1;
            end
        end
        if (req[0]) begin
            gnt_idx = '0;
            any_req = 1'b1;
        end
        rr_next = (gnt_idx == PW'(NUM_PORTS - 1)) ? PW'(1) : gnt_idx + 1'b1;
`else
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NUM_PORTS]) begin
                gnt_idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
                any_req = 1'b1;
            end
        end
        rr_next = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
`endif
    end

    // Winner's transaction fields and the one-hot grant, suppressed while reset is high.
    always_comb begin
        grant    = any_req && !reset;
        gnt      = '0;
        gnt[gnt_idx] = grant;
        g_we     = we[gnt_idx];
        g_word   = addr[int'(gnt_idx)*ADDR_WIDTH + ADDR_LSB +: IW];
        g_din    = din[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        in_range = g_word < IW'(DEPTH);
    end

    // Pointer advance plus registered read data and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= RR_RESET;
            rvalid <= '0;
            err    <= '0;
            dout   <= '0;
        end else begin
            rvalid <= '0;
            err    <= '0;
            if (grant) begin
                rr_ptr <= rr_next;
                if (g_we) begin
                    err[gnt_idx] <= !in_range;
                end else begin
                    rvalid[gnt_idx] <= 1'b1;
                    err[gnt_idx]    <= !in_range;
                    dout[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] <=
                        in_range ? mem[g_word[AW-1:0]] : '0;
                end
            end
        end
    end

    // Storage array: in-range writes land at the grant edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (grant && g_we && in_range) begin
            mem[g_word[AW-1:0]] <= g_din;
        end
    end

endmodule
